// File: rtl/apb_master_bridge.sv
// APB requester: takes one command per valid/ready handshake, runs it as SETUP then ACCESS
// on APB, and returns read data / error / timeout status on a valid/ready response port.
module apb_master_bridge #(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    input  logic [2:0]          cmd_prot,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrobe,
    output logic [2:0]          pprot,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                psel_d, penable_d, pwrite_d;
    logic [ADDR_W-1:0]   paddr_d;
    logic [DATA_W-1:0]   pwdata_d;
    logic [STRB_W-1:0]   pstrobe_d;
    logic [2:0]          pprot_d;
    logic                rsp_valid_d, rsp_err_d, rsp_timeout_d;
    logic [DATA_W-1:0]   rsp_rdata_d;
    logic                timeout_hit;

    assign cmd_ready = (state_q == IDLE);

    // cnt_q holds the number of already-elapsed waiting ACCESS cycles
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((int'(cnt_q) + 1) == TIMEOUT_CYCLES);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        psel_d        = psel;
        penable_d     = penable;
        pwrite_d      = pwrite;
        paddr_d       = paddr;
        pwdata_d      = pwdata;
        pstrobe_d     = pstrobe;
        pprot_d       = pprot;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    pstrobe_d = cmd_write ? cmd_strb : '0;
                    pprot_d   = cmd_prot;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                if (pready) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrobe     <= '0;
            pprot       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            psel        <= psel_d;
            penable     <= penable_d;
            pwrite      <= pwrite_d;
            paddr       <= paddr_d;
            pwdata      <= pwdata_d;
            pstrobe     <= pstrobe_d;
            pprot       <= pprot_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: the bench plays the APB slave and the response
// consumer, driving inputs just after each rising edge and checking outputs there.
module tb_apb_master_bridge;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int TO     = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [3:0]        cmd_strb;
    logic [2:0]        cmd_prot;
    logic              rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DATA_W-1:0] rsp_rdata;
    logic              psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [3:0]        pstrobe;
    logic [2:0]        pprot;
    logic [DATA_W-1:0] prdata;
    logic              pready, pslverr;

    int checks = 0;
    int errors = 0;

    apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrobe(pstrobe), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [3:0] s, input logic [2:0] p);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_prot  = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        cmd_prot  = '0;
        rsp_ready = 1'b1;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        tick();
        tick();
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_rsp_err", rsp_err, 0);
        resetn = 1'b1;
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);

        // 1: write, slave ready at once
        issue(1'b1, 5'h03, 32'hDEADBEEF, 4'hF, 3'd0);
        pready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("t1_setup_psel", psel, 1);
        chk("t1_setup_penable", penable, 0);
        chk("t1_paddr", paddr, 5'h03);
        chk("t1_pwrite", pwrite, 1);
        chk("t1_pwdata", pwdata, 32'hDEADBEEF);
        chk("t1_pstrobe", pstrobe, 4'hF);
        chk("t1_cmd_ready", cmd_ready, 0);
        chk("t1_rsp_valid_setup", rsp_valid, 0);
        tick();
        chk("t1_access_psel", psel, 1);
        chk("t1_access_penable", penable, 1);
        chk("t1_rsp_valid_access", rsp_valid, 0);
        tick();
        chk("t1_rsp_valid_T3", rsp_valid, 1);
        chk("t1_rsp_err", rsp_err, 0);
        chk("t1_rsp_timeout", rsp_timeout, 0);
        chk("t1_rsp_rdata", rsp_rdata, 0);
        chk("t1_psel_off", psel, 0);
        tick();
        chk("t1_rsp_valid_clr", rsp_valid, 0);
        chk("t1_cmd_ready_back", cmd_ready, 1);
        chk("t1_paddr_held", paddr, 5'h03);

        // 2: read with two wait states; pslverr without pready must be ignored
        issue(1'b0, 5'h03, 32'h0, 4'hF, 3'd5);
        pready  = 1'b0;
        pslverr = 1'b1;
        prdata  = 32'hDEADBEEF;
        tick();
        cmd_valid = 1'b0;
        chk("t2_pwrite", pwrite, 0);
        chk("t2_pstrobe_rd", pstrobe, 0);
        chk("t2_pprot", pprot, 3'd5);
        tick();
        chk("t2_acc1_penable", penable, 1);
        chk("t2_acc1_paddr", paddr, 5'h03);
        tick();
        chk("t2_acc2_penable", penable, 1);
        chk("t2_acc2_paddr", paddr, 5'h03);
        tick();
        chk("t2_acc3_penable", penable, 1);
        chk("t2_acc3_paddr", paddr, 5'h03);
        chk("t2_acc3_rsp_valid", rsp_valid, 0);
        pready  = 1'b1;
        pslverr = 1'b0;
        tick();
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("t2_rsp_err", rsp_err, 0);
        chk("t2_penable_off", penable, 0);
        tick();

        // 3: read with slave error
        issue(1'b0, 5'h07, 32'h0, 4'h0, 3'd0);
        prdata  = 32'h12345678;
        pslverr = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_rsp_err", rsp_err, 1);
        chk("t3_rsp_timeout", rsp_timeout, 0);
        chk("t3_rsp_rdata", rsp_rdata, 32'h12345678);
        tick();
        pslverr = 1'b0;
        chk("t3_cmd_ready", cmd_ready, 1);

        // 4: timeout after exactly TO ACCESS cycles
        issue(1'b0, 5'h1F, 32'h0, 4'h0, 3'd0);
        pready = 1'b0;
        prdata = 32'hCAFEF00D;
        tick();
        cmd_valid = 1'b0;
        chk("t4_setup_penable", penable, 0);
        tick();
        for (int k = 1; k <= TO; k++) begin
            chk($sformatf("t4_acc%0d_psel_penable", k), {62'd0, psel, penable}, 64'd3);
            rsp_ready = 1'b0;
            tick();
        end
        chk("t4_psel_off", psel, 0);
        chk("t4_rsp_valid", rsp_valid, 1);
        chk("t4_rsp_err", rsp_err, 1);
        chk("t4_rsp_timeout", rsp_timeout, 1);
        chk("t4_rsp_rdata", rsp_rdata, 0);

        // 5: response stalled; a competing command must not be captured
        issue(1'b1, 5'h0A, 32'hA5A5A5A5, 4'h3, 3'd2);
        pready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("t5_hold%0d_rsp_valid", k), rsp_valid, 1);
            chk($sformatf("t5_hold%0d_rsp_timeout", k), rsp_timeout, 1);
            chk($sformatf("t5_hold%0d_cmd_ready", k), cmd_ready, 0);
            chk($sformatf("t5_hold%0d_psel", k), psel, 0);
            chk($sformatf("t5_hold%0d_paddr", k), paddr, 5'h1F);
        end
        rsp_ready = 1'b1;
        tick();
        chk("t5_rsp_released", rsp_valid, 0);
        chk("t5_cmd_ready", cmd_ready, 1);
        chk("t5_not_captured", paddr, 5'h1F);
        tick();
        cmd_valid = 1'b0;
        chk("t5_new_paddr", paddr, 5'h0A);
        chk("t5_new_pstrobe", pstrobe, 4'h3);
        chk("t5_new_pprot", pprot, 3'd2);
        chk("t5_new_psel", psel, 1);
        tick();
        tick();
        chk("t5_wr_rsp_valid", rsp_valid, 1);
        chk("t5_wr_rsp_rdata", rsp_rdata, 0);
        chk("t5_wr_rsp_timeout", rsp_timeout, 0);
        tick();

        // 6: reset in the middle of ACCESS
        issue(1'b0, 5'h05, 32'h0, 4'h0, 3'd0);
        pready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("t6_in_access", penable, 1);
        resetn = 1'b0;
        tick();
        chk("t6_psel", psel, 0);
        chk("t6_penable", penable, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_paddr_clr", paddr, 0);
        resetn = 1'b1;
        pready = 1'b1;
        tick();
        chk("t6_cmd_ready", cmd_ready, 1);
        chk("t6_no_rsp", rsp_valid, 0);
        chk("t6_psel_idle", psel, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
